csr_access_unit: RTL and testbench
==================================

// Module: csr_access_unit
// PURPOSE
// - Initiator side of the CSR file read/write port. Executes Zicsr instructions
//   (CSRRW/CSRRS/CSRRC and their immediate forms) as a read-modify-write sequence.
// - Sits beside execute. Takes one CSR request, drives the CSR file's read index,
//   then its write index, data and enable. Returns the old CSR value for rd to writeback.
// - Flags unmapped CSR addresses as illegal instruction (mcause 4'h2) towards trap control.
// PARAMETERS
// - XLEN          32     data width
// - CSR_ADDR_W    12     architectural CSR address width
// PORTS
// - clock              in   1     clock
// - reset              in   1     synchronous, active-high reset
// - req_valid          in   1     CSR instruction presented
// - req_ready          out  1     unit can accept (high only in IDLE)
// - req_addr           in   12    instruction CSR address
// - req_funct3         in   3     001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
// - req_rs1_data       in   32    rs1 value (register forms)
// - req_zimm           in   5     uimm field; for register forms, holds the rs1 index
// - req_rd             in   5     destination register index
// - flush              in   1     pipeline flush (controlReset); aborts the op
// - read_csr           out  4     destinationCSR_ index driven to the CSR file read port
// - csr_read_data      in   32    combinational read data from the CSR file
// - write_csr          out  4     destinationCSR_ index for the write
// - csr_write_data     out  32    write data
// - csr_write_en       out  1     one-cycle write strobe
// - resp_valid         out  1     result ready for writeback
// - resp_ready         in   1     writeback consumed the result
// - resp_rd            out  5     rd index
// - resp_data          out  32    old CSR value
// - exc_valid          out  1     one-cycle illegal-instruction pulse
// - exc_cause          out  4     4'h2 when exc_valid is high, else 0
// BEHAVIOUR
// - Reset: FSM in IDLE. All outputs are 0, except req_ready=1.
// - FSM states and transitions:
//   - IDLE: if req_valid && !flush, latch the request and go to READ.
//   - READ: drive read_csr from the latched index; register csr_read_data into old_q.
//     - Unmapped address: pulse exc_valid and return to IDLE. No write, no resp.
//     - Otherwise go to WRITE.
//   - WRITE: csr_write_en=1 for exactly one cycle, only if do_write. Then go to RESP.
//   - RESP: resp_valid=1 and held until resp_ready; return to IDLE in the handshake cycle.
// - Latency: accept at cycle 0, read at 1, write at 2, resp_valid from cycle 3.
// - Throughput: a new request is not accepted until the cycle after the RESP handshake.
// - Write data:
//   - RW: src.  RS: old_q | src.  RC: old_q & ~src.
//   - src = rs1_data for register forms; src = {27'b0, zimm} for immediate forms.
// - do_write rules:
//   - RW/RWI: always write (rd=x0 does not suppress the write).
//   - RS/RC/RSI/RCI: write only if the zimm field (the rs1 index for register forms) is nonzero.
// - The read is always performed; CSR reads have no side effects.
// - Counters: writing MCYCLE/MINSTRET is legal. The CSR file arbitrates against its own increment.
// - Flush:
//   - Flush in any state returns to IDLE next cycle, with no write strobe and no resp.
//   - Flush overrides csr_write_en in the same cycle it is asserted.
//   - Flush with req_valid in IDLE: the request is not accepted.
// - Reset mid-operation: immediate return to IDLE; no strobe in the reset cycle.
// - funct3 000/100 never reach this unit; if presented, treat as illegal.
// CONFIGURATION
// - CSR_RO_CHECK_EN defined:
//   - A write attempt (do_write=1) to MISA, or to an address with addr[11:10]==2'b11,
//     raises exc_valid (cause 2) in READ. No write, no resp.
// - CSR_RO_CHECK_EN undefined:
//   - Such writes are issued normally. The RMW behaves as for any mapped CSR.
// STRUCTURE
// - pack additions:
//   - csr_op_e {CSR_RW, CSR_RS, CSR_RC}
//   - CSR address localparams: MSTATUS 0x300, MISA 0x301, MTVEC 0x305, MEPC 0x341,
//     MCAUSE 0x342, MTVAL 0x343, MCYCLE 0xB00, MINSTRET 0xB02
//   - EXC_ILLEGAL_INSTR = 4'h2
//   - Reuse destinationCSR_ for the indices.
// - Sub-module csr_addr_decode (combinational): 12-bit address -> {hit, destinationCSR_ idx, read_only}.
// - FSM and datapath stay in this module.
// TESTING
// - Reset -> req_ready=1; csr_write_en, resp_valid, exc_valid all 0.
// - CSRRW 0x305, rs1=0x80, MTVEC=0 -> cycle 2: write_csr=MTVEC, data 0x80, en=1;
//   cycle 3: resp_data=0.
// - CSRRC 0x300, rs1=0x800, rs1 idx 5, MSTATUS=0x1800 -> csr_write_data=0x1000; resp_data=0x1800.
// - CSRRS 0xB00, rs1 idx 0 -> csr_write_en stays 0 for the whole op; resp_data = MCYCLE sampled in READ.
// - CSRRW 0x7C0 -> exc_valid=1, exc_cause=2 in cycle 1; no write, no resp_valid.
// - Flush in WRITE (mepc RWI, zimm=3) -> csr_write_en=0; IDLE next cycle.
// - CSR_RO_CHECK_EN on, CSRRW 0x301 -> exc_valid; with it undefined, the write strobe fires instead.

Source files
------------

// File: rtl/csr_access_unit_pkg.sv
// Shared types and constants for the CSR access unit: operation kinds,
// architectural CSR addresses, CSR file index encoding and FSM states.
package csr_access_unit_pkg;

    localparam int XLEN       = 32;
    localparam int CSR_ADDR_W = 12;

    // Read-modify-write flavour, taken from funct3[1:0]
    typedef enum logic [1:0] {
        CSR_RW,
        CSR_RS,
        CSR_RC
    } csr_op_e;

    // Architectural CSR addresses handled by the CSR file
    localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MSTATUS  = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MISA     = 12'h301;
    localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MTVEC    = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MEPC     = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MCAUSE   = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MTVAL    = 12'h343;
    localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MCYCLE   = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MINSTRET = 12'hB02;

    localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'h2;

    // Physical register index inside the CSR file; CSR_NONE means no register
    typedef enum logic [3:0] {
        CSR_NONE     = 4'd0,
        CSR_MSTATUS  = 4'd1,
        CSR_MISA     = 4'd2,
        CSR_MTVEC    = 4'd3,
        CSR_MEPC     = 4'd4,
        CSR_MCAUSE   = 4'd5,
        CSR_MTVAL    = 4'd6,
        CSR_MCYCLE   = 4'd7,
        CSR_MINSTRET = 4'd8
    } destinationCSR_;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } csr_state_e;

    // Request fields captured at accept time
    typedef struct packed {
        logic [CSR_ADDR_W-1:0] addr;
        logic [2:0]            funct3;
        logic [XLEN-1:0]       rs1_data;
        logic [4:0]            zimm;
        logic [4:0]            rd;
    } csr_req_t;

    // funct3[1:0] selects the operation; 00 is not a Zicsr encoding
    function automatic csr_op_e funct3_to_op(input logic [2:0] funct3);
        csr_op_e op;
        case (funct3[1:0])
            2'b01:   op = CSR_RW;
            2'b10:   op = CSR_RS;
            default: op = CSR_RC;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/csr_addr_decode.sv
// Combinational CSR address decoder: maps an architectural address to the
// CSR file index and flags read-only addresses (MISA and the 0xC00-0xFFF range).
module csr_addr_decode
    import csr_access_unit_pkg::*;
(
    input  logic [CSR_ADDR_W-1:0] addr,
    output logic                  hit,
    output destinationCSR_        idx,
    output logic                  read_only
);

    // Address lookup; unmapped addresses miss and select no register
    always_comb begin
        hit       = 1'b1;
        idx       = CSR_NONE;
        read_only = (addr == CSR_ADDR_MISA) || (addr[11:10] == 2'b11);
        unique case (addr)
            CSR_ADDR_MSTATUS:  idx = CSR_MSTATUS;
            CSR_ADDR_MISA:     idx = CSR_MISA;
            CSR_ADDR_MTVEC:    idx = CSR_MTVEC;
            CSR_ADDR_MEPC:     idx = CSR_MEPC;
            CSR_ADDR_MCAUSE:   idx = CSR_MCAUSE;
            CSR_ADDR_MTVAL:    idx = CSR_MTVAL;
            CSR_ADDR_MCYCLE:   idx = CSR_MCYCLE;
            CSR_ADDR_MINSTRET: idx = CSR_MINSTRET;
            default:           hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: runs one Zicsr instruction as accept -> read -> write -> respond.
// Unmapped addresses and bad funct3 raise an illegal-instruction pulse in READ.
// Build option CSR_RO_CHECK_EN: when defined, write attempts to read-only CSRs
// are also reported as illegal instead of being issued to the CSR file.
module csr_access_unit
    import csr_access_unit_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CSR_ADDR_W-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [XLEN-1:0]       req_rs1_data,
    input  logic [4:0]            req_zimm,
    input  logic [4:0]            req_rd,
    input  logic                  flush,
    output logic [3:0]            read_csr,
    input  logic [XLEN-1:0]       csr_read_data,
    output logic [3:0]            write_csr,
    output logic [XLEN-1:0]       csr_write_data,
    output logic                  csr_write_en,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [4:0]            resp_rd,
    output logic [XLEN-1:0]       resp_data,
    output logic                  exc_valid,
    output logic [3:0]            exc_cause
);

    csr_state_e      state_q, state_d;
    csr_req_t        req_q, req_d;
    logic [XLEN-1:0] old_q, old_d;

    logic            dec_hit;
    destinationCSR_  dec_idx;
    logic            dec_ro;

    csr_op_e         op;
    logic            op_legal;
    logic [XLEN-1:0] src;
    logic            do_write;
    logic [XLEN-1:0] write_value;
    logic            illegal;

    csr_addr_decode u_decode (
        .addr      (req_q.addr),
        .hit       (dec_hit),
        .idx       (dec_idx),
        .read_only (dec_ro)
    );

    // Operand selection, write-enable rule and read-modify-write result
    always_comb begin
        op       = funct3_to_op(req_q.funct3);
        op_legal = (req_q.funct3[1:0] != 2'b00);
        src      = req_q.funct3[2] ? {{(XLEN-5){1'b0}}, req_q.zimm} : req_q.rs1_data;
        // Set/clear with a zero source field is a pure read; RW always writes
        do_write = (op == CSR_RW) || (req_q.zimm != 5'd0);
        unique case (op)
            CSR_RW:  write_value = src;
            CSR_RS:  write_value = old_q | src;
            default: write_value = old_q & ~src;
        endcase
    end

`ifdef CSR_RO_CHECK_EN
    // Unmapped, malformed, or a write aimed at a read-only CSR
    always_comb begin
        illegal = !dec_hit || !op_legal || (dec_ro && do_write);
    end
`else
    logic unused_ro;
    assign unused_ro = dec_ro;

    // Unmapped or malformed; read-only CSRs are written like any other
    always_comb begin
        illegal = !dec_hit || !op_legal;
    end
`endif

    // Next-state and output decode; flush or reset silences every strobe
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        old_d          = old_q;
        req_ready      = 1'b0;
        read_csr       = 4'd0;
        write_csr      = 4'd0;
        csr_write_data = '0;
        csr_write_en   = 1'b0;
        resp_valid     = 1'b0;
        resp_rd        = 5'd0;
        resp_data      = '0;
        exc_valid      = 1'b0;
        exc_cause      = 4'd0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !flush) begin
                    req_d.addr     = req_addr;
                    req_d.funct3   = req_funct3;
                    req_d.rs1_data = req_rs1_data;
                    req_d.zimm     = req_zimm;
                    req_d.rd       = req_rd;
                    state_d        = ST_READ;
                end
            end
            ST_READ: begin
                read_csr = dec_idx;
                old_d    = csr_read_data;
                if (illegal) begin
                    exc_valid = 1'b1;
                    exc_cause = EXC_ILLEGAL_INSTR;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                write_csr      = dec_idx;
                csr_write_data = write_value;
                csr_write_en   = do_write;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rd    = req_q.rd;
                resp_data  = old_q;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (flush || reset) begin
            read_csr       = 4'd0;
            write_csr      = 4'd0;
            csr_write_data = '0;
            csr_write_en   = 1'b0;
            resp_valid     = 1'b0;
            resp_rd        = 5'd0;
            resp_data      = '0;
            exc_valid      = 1'b0;
            exc_cause      = 4'd0;
        end
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // State, latched request and captured old CSR value
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            old_q   <= old_d;
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: a small CSR file in the bench answers reads,
// and a transaction-level model predicts every output on every cycle.
module tb_csr_access_unit;
    import csr_access_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_zimm;
    logic [4:0]  req_rd;
    logic        flush;
    logic [3:0]  read_csr;
    logic [31:0] csr_read_data;
    logic [3:0]  write_csr;
    logic [31:0] csr_write_data;
    logic        csr_write_en;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        exc_valid;
    logic [3:0]  exc_cause;

    always #5 clock = ~clock;

    csr_access_unit dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_funct3     (req_funct3),
        .req_rs1_data   (req_rs1_data),
        .req_zimm       (req_zimm),
        .req_rd         (req_rd),
        .flush          (flush),
        .read_csr       (read_csr),
        .csr_read_data  (csr_read_data),
        .write_csr      (write_csr),
        .csr_write_data (csr_write_data),
        .csr_write_en   (csr_write_en),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rd        (resp_rd),
        .resp_data      (resp_data),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause)
    );

`ifdef CSR_RO_CHECK_EN
    localparam bit RO_CHECK = 1'b1;
`else
    localparam bit RO_CHECK = 1'b0;
`endif

    // Bench-side CSR file: combinational read port
    logic [31:0] env [16];
    assign csr_read_data = env[read_csr];

    logic [11:0] addr_tab [8] = '{12'h300, 12'h301, 12'h305, 12'h341,
                                  12'h342, 12'h343, 12'hB00, 12'hB02};
    logic [3:0]  idx_tab  [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model: busy flag, age = cycles since accept, latched request
    bit          busy = 1'b0;
    int          age  = 0;
    logic [11:0] m_addr;
    logic [2:0]  m_f3;
    logic [31:0] m_rs1;
    logic [4:0]  m_zimm;
    logic [4:0]  m_rd;
    logic [31:0] m_old;
    bit          m_illegal;

    // Captured DUT outputs of the last cycle, for literal checks
    logic        cap_ready, cap_wen, cap_rv, cap_exc;
    logic [3:0]  cap_read, cap_wcsr, cap_cause;
    logic [31:0] cap_wdata, cap_rdata;

    function automatic logic [3:0] map_idx(input logic [11:0] a);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 8; i++) if (addr_tab[i] == a) r = idx_tab[i];
        return r;
    endfunction

    function automatic bit model_do_write(input logic [2:0] f3, input logic [4:0] zimm);
        return (f3[1:0] == 2'b01) || (zimm != 5'd0);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs1,
                                                input logic [4:0] zimm, input logic [31:0] old);
        logic [31:0] s;
        s = f3[2] ? {27'd0, zimm} : rs1;
        if (f3[1:0] == 2'b01) return s;
        if (f3[1:0] == 2'b10) return old | s;
        return old & ~s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, compare every output against the model, advance
    task automatic run_cycle(input bit rst, input bit vld, input logic [11:0] a,
                             input logic [2:0] f3, input logic [31:0] rs1,
                             input logic [4:0] zi, input logic [4:0] rd,
                             input bit fl, input bit rr);
        logic        e_ready, e_wen, e_rv, e_exc;
        logic [3:0]  e_read, e_wcsr, e_cause;
        logic [31:0] e_wdata, e_rdata;
        bit          pend_wr;
        @(negedge clock);
        reset = rst; req_valid = vld; req_addr = a; req_funct3 = f3;
        req_rs1_data = rs1; req_zimm = zi; req_rd = rd; flush = fl; resp_ready = rr;
        #1;
        e_ready = !busy; e_wen = 0; e_rv = 0; e_exc = 0; e_read = 0; e_wcsr = 0;
        e_cause = 0; e_wdata = 0; e_rdata = 0; pend_wr = 0;
        if (busy && !rst && !fl) begin
            if (age == 1) begin
                e_read = map_idx(m_addr);
                m_old  = env[e_read];
                if (m_illegal) begin e_exc = 1; e_cause = 4'h2; end
            end else if (age == 2) begin
                e_wcsr  = map_idx(m_addr);
                e_wdata = model_wdata(m_f3, m_rs1, m_zimm, m_old);
                e_wen   = model_do_write(m_f3, m_zimm);
                pend_wr = e_wen;
            end else begin
                e_rv = 1; e_rrd_set(e_rdata);
            end
        end
        cap_ready = req_ready; cap_wen = csr_write_en; cap_rv = resp_valid; cap_exc = exc_valid;
        cap_read = read_csr; cap_wcsr = write_csr; cap_cause = exc_cause;
        cap_wdata = csr_write_data; cap_rdata = resp_data;
        if (cmp_en) begin
            chk("req_ready", req_ready, e_ready);
            chk("read_csr", read_csr, e_read);
            chk("write_csr", write_csr, e_wcsr);
            chk("csr_write_data", csr_write_data, e_wdata);
            chk("csr_write_en", csr_write_en, e_wen);
            chk("resp_valid", resp_valid, e_rv);
            chk("resp_rd", resp_rd, e_rv ? m_rd : 5'd0);
            chk("resp_data", resp_data, e_rdata);
            chk("exc_valid", exc_valid, e_exc);
            chk("exc_cause", exc_cause, e_cause);
        end
        if (rst) busy = 0;
        else if (!busy) begin
            if (vld && !fl) begin
                busy = 1; age = 1;
                m_addr = a; m_f3 = f3; m_rs1 = rs1; m_zimm = zi; m_rd = rd;
                m_illegal = (map_idx(a) == 4'd0) || (f3[1:0] == 2'b00) ||
                            (RO_CHECK && model_do_write(f3, zi) &&
                             ((a == 12'h301) || (a[11:10] == 2'b11)));
            end
        end
        else if (fl) busy = 0;
        else if (age == 1) begin if (m_illegal) busy = 0; else age = 2; end
        else if (age == 2) age = 3;
        else if (rr) busy = 0;
        @(posedge clock);
        #1;
        env[7] = env[7] + 32'd1;
        if (pend_wr) env[map_idx(m_addr)] = model_wdata(m_f3, m_rs1, m_zimm, m_old);
    endtask

    task automatic e_rrd_set(output logic [31:0] d);
        d = m_old;
    endtask

    task automatic idle(input bit rr);
        run_cycle(0, 0, 12'h0, 3'd0, 32'h0, 5'd0, 5'd0, 0, rr);
    endtask

    task automatic issue(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [4:0] zi, input logic [4:0] rd);
        run_cycle(0, 1, a, f3, rs1, zi, rd, 0, 1);
    endtask

    logic [31:0] mc_sample;
    logic [11:0] ra;
    int          r;

    initial begin
        for (int i = 0; i < 16; i++) env[i] = 32'h1000 * i + 32'h11;
        reset = 1; req_valid = 0; req_addr = 0; req_funct3 = 0; req_rs1_data = 0;
        req_zimm = 0; req_rd = 0; flush = 0; resp_ready = 0;
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cmp_en = 1'b1;

        // Reset state
        idle(0);
        chk("lit_reset_ready", cap_ready, 1);
        chk("lit_reset_wen", cap_wen, 0);
        chk("lit_reset_rv", cap_rv, 0);
        chk("lit_reset_exc", cap_exc, 0);

        // CSRRW mtvec, resp held until resp_ready
        env[3] = 32'h0;
        issue(12'h305, 3'b001, 32'h80, 5'd1, 5'd7);
        idle(0);
        idle(0);
        chk("lit_rw_wcsr", cap_wcsr, 4'd3);
        chk("lit_rw_wdata", cap_wdata, 32'h80);
        chk("lit_rw_wen", cap_wen, 1);
        idle(0);
        chk("lit_rw_rv", cap_rv, 1);
        chk("lit_rw_rdata", cap_rdata, 32'h0);
        idle(1);
        chk("lit_rw_hold", cap_rv, 1);
        idle(1);
        chk("lit_rw_ready_after", cap_ready, 1);

        // CSRRC mstatus
        env[1] = 32'h1800;
        issue(12'h300, 3'b011, 32'h800, 5'd5, 5'd3);
        idle(1);
        idle(1);
        chk("lit_rc_wdata", cap_wdata, 32'h1000);
        idle(1);
        chk("lit_rc_rdata", cap_rdata, 32'h1800);

        // CSRRS mcycle with rs1 index 0: pure read
        issue(12'hB00, 3'b010, 32'hFFFF, 5'd0, 5'd9);
        mc_sample = env[7];
        idle(1);
        idle(1);
        chk("lit_rs0_wen", cap_wen, 0);
        idle(1);
        chk("lit_rs0_rdata", cap_rdata, mc_sample);

        // Unmapped address
        issue(12'h7C0, 3'b001, 32'h5, 5'd1, 5'd2);
        idle(1);
        chk("lit_unmapped_exc", cap_exc, 1);
        chk("lit_unmapped_cause", cap_cause, 4'h2);
        idle(1);
        chk("lit_unmapped_rv", cap_rv, 0);
        chk("lit_unmapped_wen", cap_wen, 0);
        chk("lit_unmapped_idle", cap_ready, 1);

        // Flush in WRITE
        issue(12'h341, 3'b101, 32'h0, 5'd3, 5'd4);
        idle(1);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("lit_flush_wen", cap_wen, 0);
        idle(1);
        chk("lit_flush_idle", cap_ready, 1);

        // Flush with req_valid in IDLE: not accepted
        run_cycle(0, 1, 12'h300, 3'b001, 32'h1, 5'd1, 5'd1, 1, 1);
        idle(1);
        chk("lit_flush_idle_noread", cap_read, 0);

        // Reset mid-operation
        issue(12'h342, 3'b001, 32'h9, 5'd1, 5'd1);
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("lit_rst_mid_exc", cap_exc, 0);
        idle(1);
        chk("lit_rst_mid_ready", cap_ready, 1);

        // Write to MISA
        issue(12'h301, 3'b001, 32'h5, 5'd1, 5'd1);
        idle(1);
        chk("lit_misa_exc", cap_exc, RO_CHECK ? 1 : 0);
        idle(1);
        chk("lit_misa_wen", cap_wen, RO_CHECK ? 0 : 1);
        idle(1);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) ra = addr_tab[$urandom_range(0, 7)];
            else if (r < 80) ra = 12'hC00 + 12'($urandom_range(0, 3));
            else ra = 12'($urandom);
            run_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), ra,
                      3'($urandom_range(0, 7)), $urandom,
                      ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                      5'($urandom), ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
